// File: rtl/aes_pkcs7_pad_pkg.sv
// aes_pkg: AES constants, padder FSM state type and a byte-enable popcount helper.
package aes_pkg;

  localparam int unsigned AES_BLOCK_BYTES = 16;
  localparam int unsigned AES_BLOCK_BITS  = 8 * AES_BLOCK_BYTES;
  localparam int unsigned AES128_KEY_LEN  = 128;
  localparam int unsigned AES192_KEY_LEN  = 192;
  localparam int unsigned AES256_KEY_LEN  = 256;

  typedef enum logic [1:0] {
    ST_KEY  = 2'd0,
    ST_IV   = 2'd1,
    ST_DATA = 2'd2,
    ST_PAD  = 2'd3
  } pad_state_e;

  // Number of set bits in a byte-enable vector (zero-extended to 16 bits).
  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) begin
      n = n + 5'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/aes_pkcs7_pad_if.sv
// AXI-Stream channel carrying key, IV and message beats plus the encrypt/decrypt mode bit.
interface aes_pkcs7_pad_if #(
  parameter int unsigned AXIS_WIDTH = 64
);

  logic                    tvalid;
  logic                    tready;
  logic [AXIS_WIDTH-1:0]   tdata;
  logic [AXIS_WIDTH/8-1:0] tkeep;
  logic                    tlast;
  logic                    tuser;

  modport master (output tvalid, tdata, tkeep, tlast, tuser, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, tuser, output tready);

endinterface

// File: rtl/aes_pkcs7_pad_fill.sv
// aes_pkcs7_fill: replaces every disabled byte of a beat with the PKCS#7 pad value.
module aes_pkcs7_fill #(
  parameter int unsigned AXIS_WIDTH = 64
) (
  input  logic [AXIS_WIDTH-1:0]   word,
  input  logic [AXIS_WIDTH/8-1:0] tkeep,
  input  logic [4:0]              pad,
  output logic [AXIS_WIDTH-1:0]   filled_c
);

  localparam int unsigned BYTES = AXIS_WIDTH / 8;

  // Keep enabled bytes, overwrite the rest with the pad count.
  always_comb begin
    filled_c = word;
    for (int i = 0; i < BYTES; i++) begin
      if (!tkeep[i]) begin
        filled_c[8*i +: 8] = 8'(pad);
      end
    end
  end

endmodule

// File: rtl/aes_pkcs7_pad.sv
// aes_pkcs7_pad: forwards key/IV/data beats to the CBC core and appends PKCS#7 padding
// to encrypt messages. Define AES_PAD_ERR_EN to add the sticky Pad_error output.
module aes_pkcs7_pad
  import aes_pkg::*;
#(
  parameter int unsigned AXIS_WIDTH = 64,
  parameter int unsigned KEY_LENGTH = AES256_KEY_LEN
) (
  input  logic            Clk,
  input  logic            Rst,
  aes_pkcs7_pad_if.slave  S_axis,
  aes_pkcs7_pad_if.master M_axis
`ifdef AES_PAD_ERR_EN
  ,
  output logic            Pad_error
`endif
);

  localparam int unsigned BYTES      = AXIS_WIDTH / 8;
  localparam int unsigned KEY_BEATS  = KEY_LENGTH / AXIS_WIDTH;
  localparam int unsigned IV_BEATS   = AES_BLOCK_BITS / AXIS_WIDTH;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned OFF_W      = 4;
  localparam int unsigned P_W        = 5;
  localparam int unsigned REM_W      = 6;
  localparam int unsigned BYTE_SHIFT = $clog2(BYTES);

  if (!(AXIS_WIDTH == 32 || AXIS_WIDTH == 64 || AXIS_WIDTH == 128)) begin : g_bad_width
    $error("aes_pkcs7_pad: AXIS_WIDTH must be 32, 64 or 128");
  end
  if (!(KEY_LENGTH == AES128_KEY_LEN || KEY_LENGTH == AES192_KEY_LEN ||
        KEY_LENGTH == AES256_KEY_LEN)) begin : g_bad_key
    $error("aes_pkcs7_pad: KEY_LENGTH must be 128, 192 or 256");
  end

  pad_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [OFF_W-1:0]      off_q, off_d;
  logic                  mode_q, mode_d;
  logic [P_W-1:0]        pad_q, pad_d;
  logic [P_W-1:0]        pad_left_q, pad_left_d;
  logic                  m_valid_q, m_valid_d;
  logic [AXIS_WIDTH-1:0] m_data_q, m_data_d;
  logic [BYTES-1:0]      m_keep_q, m_keep_d;
  logic                  m_last_q, m_last_d;
  logic                  m_user_q, m_user_d;

  logic                  m_adv_c;
  logic                  s_ready_c;
  logic                  s_fire_c;
  logic                  mode_in_c;
  logic [4:0]            pc_c;
  logic [OFF_W-1:0]      off_sum_c;
  logic [P_W-1:0]        p_c;
  logic [REM_W-1:0]      pad_rem_c;
  logic [P_W-1:0]        pad_words_c;
  logic [AXIS_WIDTH-1:0] filled_c;

  // Output register can take a new word when empty or being drained this cycle.
  assign m_adv_c   = !m_valid_q || M_axis.tready;
  assign s_ready_c = !Rst && (state_q != ST_PAD) && m_adv_c;
  assign s_fire_c  = S_axis.tvalid && s_ready_c;

  // Mode comes from tuser of key word 0, then from the latched copy.
  assign mode_in_c = (cnt_q == '0) ? S_axis.tuser : mode_q;

  // Running byte offset within the AES block and the resulting pad count.
  assign pc_c      = popcount16(16'(S_axis.tkeep));
  assign off_sum_c = OFF_W'(5'(off_q) + pc_c);
  assign p_c       = P_W'(AES_BLOCK_BYTES) - P_W'(off_sum_c);

  // Pad bytes left after filling the last beat's holes, expressed in whole words.
  assign pad_rem_c   = REM_W'(p_c) + REM_W'(pc_c);
  assign pad_words_c = (pad_rem_c > REM_W'(BYTES)) ?
                       P_W'((pad_rem_c - REM_W'(BYTES)) >> BYTE_SHIFT) : '0;

  aes_pkcs7_fill #(
    .AXIS_WIDTH (AXIS_WIDTH)
  ) u_fill (
    .word     (S_axis.tdata),
    .tkeep    (S_axis.tkeep),
    .pad      (p_c),
    .filled_c (filled_c)
  );

  // Next-state and output-register loading for the key/IV/data/pad sequence.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    off_d      = off_q;
    mode_d     = mode_q;
    pad_d      = pad_q;
    pad_left_d = pad_left_q;
    m_valid_d  = m_valid_q && !m_adv_c;
    m_data_d   = m_data_q;
    m_keep_d   = m_keep_q;
    m_last_d   = m_last_q;
    m_user_d   = m_user_q;

    unique case (state_q)
      ST_KEY: begin
        if (s_fire_c) begin
          m_valid_d = 1'b1;
          m_data_d  = S_axis.tdata;
          m_keep_d  = S_axis.tkeep;
          m_last_d  = S_axis.tlast;
          m_user_d  = mode_in_c;
          if (cnt_q == '0) begin
            mode_d = S_axis.tuser;
          end
          if (S_axis.tlast) begin
            cnt_d = '0;
          end else if (cnt_q == CNT_W'(KEY_BEATS - 1)) begin
            state_d = ST_IV;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      ST_IV: begin
        if (s_fire_c) begin
          m_valid_d = 1'b1;
          m_data_d  = S_axis.tdata;
          m_keep_d  = S_axis.tkeep;
          m_last_d  = S_axis.tlast;
          m_user_d  = mode_q;
          if (S_axis.tlast) begin
            state_d = ST_KEY;
            cnt_d   = '0;
          end else if (cnt_q == CNT_W'(IV_BEATS - 1)) begin
            state_d = ST_DATA;
            cnt_d   = '0;
            off_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      ST_DATA: begin
        if (s_fire_c) begin
          m_valid_d = 1'b1;
          m_user_d  = mode_q;
          off_d     = off_sum_c;
          if (mode_q) begin
            m_keep_d = '1;
            if (S_axis.tlast) begin
              m_data_d   = filled_c;
              m_last_d   = (pad_words_c == '0);
              pad_d      = p_c;
              pad_left_d = pad_words_c;
              off_d      = '0;
              state_d    = (pad_words_c == '0) ? ST_KEY : ST_PAD;
            end else begin
              m_data_d = S_axis.tdata;
              m_last_d = 1'b0;
            end
          end else begin
            m_data_d = S_axis.tdata;
            m_keep_d = S_axis.tkeep;
            m_last_d = S_axis.tlast;
            if (S_axis.tlast) begin
              off_d   = '0;
              state_d = ST_KEY;
            end
          end
        end
      end

      ST_PAD: begin
        if (m_adv_c) begin
          if (pad_left_q != '0) begin
            m_valid_d  = 1'b1;
            m_data_d   = {BYTES{8'(pad_q)}};
            m_keep_d   = '1;
            m_last_d   = (pad_left_q == P_W'(1));
            m_user_d   = mode_q;
            pad_left_d = pad_left_q - P_W'(1);
          end else begin
            state_d = ST_KEY;
            cnt_d   = '0;
          end
        end
      end

      default: begin
        state_d = ST_KEY;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= ST_KEY;
      cnt_q      <= '0;
      off_q      <= '0;
      mode_q     <= 1'b0;
      pad_q      <= '0;
      pad_left_q <= '0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_keep_q   <= '0;
      m_last_q   <= 1'b0;
      m_user_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      off_q      <= off_d;
      mode_q     <= mode_d;
      pad_q      <= pad_d;
      pad_left_q <= pad_left_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      m_keep_q   <= m_keep_d;
      m_last_q   <= m_last_d;
      m_user_q   <= m_user_d;
    end
  end

  assign S_axis.tready = s_ready_c;
  assign M_axis.tvalid = m_valid_q;
  assign M_axis.tdata  = m_data_q;
  assign M_axis.tkeep  = m_keep_q;
  assign M_axis.tlast  = m_last_q;
  assign M_axis.tuser  = m_user_q;

`ifdef AES_PAD_ERR_EN
  logic             err_q;
  logic             err_set_c;
  logic [BYTES-1:0] keep_inc_c;

  assign keep_inc_c = S_axis.tkeep + BYTES'(1);

  // Flag malformed framing: bad tkeep shapes, early tlast, unaligned decrypt length.
  always_comb begin
    err_set_c = 1'b0;
    if (s_fire_c) begin
      unique case (state_q)
        ST_KEY, ST_IV: err_set_c = S_axis.tlast;
        ST_DATA: begin
          if (!S_axis.tlast) begin
            err_set_c = (S_axis.tkeep != '1);
          end else begin
            err_set_c = (S_axis.tkeep == '0) ||
                        ((S_axis.tkeep & keep_inc_c) != '0) ||
                        (!mode_q && (off_sum_c != '0));
          end
        end
        default: err_set_c = 1'b0;
      endcase
    end
  end

  // Sticky until reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      err_q <= 1'b0;
    end else if (err_set_c) begin
      err_q <= 1'b1;
    end
  end

  assign Pad_error = err_q;
`endif

endmodule

// File: tb/tb_aes_pkcs7_pad.sv
// Directed, table-driven bench for aes_pkcs7_pad (AXIS_WIDTH=64, KEY_LENGTH=256).
module tb_aes_pkcs7_pad;

  localparam int unsigned W = 64;

  logic Clk = 1'b0;
  logic Rst;

  always #5 Clk = ~Clk;

  aes_pkcs7_pad_if #(.AXIS_WIDTH(W)) S_axis ();
  aes_pkcs7_pad_if #(.AXIS_WIDTH(W)) M_axis ();

`ifdef AES_PAD_ERR_EN
  logic Pad_error;
`endif

  aes_pkcs7_pad #(
    .AXIS_WIDTH (W),
    .KEY_LENGTH (256)
  ) dut (
    .Clk    (Clk),
    .Rst    (Rst),
    .S_axis (S_axis),
    .M_axis (M_axis)
`ifdef AES_PAD_ERR_EN
    ,
    .Pad_error (Pad_error)
`endif
  );

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        user;
  } beat_t;

  typedef struct {
    bit          has_in;
    logic [63:0] in_data;
    logic [7:0]  in_keep;
    bit          in_last;
    bit          has_out;
    logic [63:0] exp_data;
    logic [7:0]  exp_keep;
    bit          exp_last;
  } vec_t;

  typedef struct {
    string name;
    bit    mode;
    int    first;
    int    num;
    bit    has_pad;
  } test_t;

  vec_t  rows[$];
  test_t tests[$];
  int    n_vec  = 0;
  int    n_fail = 0;

  function automatic void add_row(bit hi, logic [63:0] id, logic [7:0] ik, bit il,
                                  bit ho, logic [63:0] ed, logic [7:0] ek, bit el);
    vec_t v;
    v.has_in = hi; v.in_data = id; v.in_keep = ik; v.in_last = il;
    v.has_out = ho; v.exp_data = ed; v.exp_keep = ek; v.exp_last = el;
    rows.push_back(v);
  endfunction

  function automatic void add_test(string name, bit mode, int n, bit has_pad);
    test_t t;
    t.name = name; t.mode = mode; t.num = n; t.has_pad = has_pad;
    t.first = rows.size() - n;
    tests.push_back(t);
  endfunction

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic check_beat(input string name, input int idx, input beat_t got, input beat_t exp);
    n_vec++;
    if (got.data !== exp.data || got.keep !== exp.keep ||
        got.last !== exp.last || got.user !== exp.user) begin
      n_fail++;
      $display("FAIL %s out beat %0d: got data=%h keep=%h last=%b user=%b, want data=%h keep=%h last=%b user=%b",
               name, idx, got.data, got.keep, got.last, got.user,
               exp.data, exp.keep, exp.last, exp.user);
    end
  endtask

  // Sends key, IV and the table rows of test t; compares every M handshake in order.
  task automatic run_msg(input int t, input bit toggle, input bit abort_pad);
    beat_t stim[$];
    beat_t exp[$];
    beat_t b;
    beat_t got;
    int    si      = 0;
    int    oi      = 0;
    int    cyc     = 0;
    int    pad_rdy = 0;
    int    busy    = 0;
    bit    mode    = tests[t].mode;

    for (int k = 0; k < 4; k++) begin
      b.data = 64'hC0DE_0000_0000_0000 + 64'(k);
      b.keep = 8'hFF;
      b.last = 1'b0;
      b.user = (k == 0) ? mode : ~mode;
      stim.push_back(b);
      b.user = mode;
      exp.push_back(b);
    end
    for (int k = 0; k < 2; k++) begin
      b.data = 64'h1717_2828_0000_0000 + 64'(k);
      b.keep = 8'hFF;
      b.last = 1'b0;
      b.user = ~mode;
      stim.push_back(b);
      b.user = mode;
      exp.push_back(b);
    end
    for (int r = tests[t].first; r < tests[t].first + tests[t].num; r++) begin
      if (rows[r].has_in) begin
        b.data = rows[r].in_data; b.keep = rows[r].in_keep;
        b.last = rows[r].in_last; b.user = ~mode;
        stim.push_back(b);
      end
      if (rows[r].has_out) begin
        b.data = rows[r].exp_data; b.keep = rows[r].exp_keep;
        b.last = rows[r].exp_last; b.user = mode;
        exp.push_back(b);
      end
    end

    M_axis.tready = 1'b1;
    while ((abort_pad ? (si < stim.size()) : (exp.size() > 0)) && cyc < 400) begin
      @(negedge Clk);
      if (si < stim.size()) begin
        S_axis.tvalid = 1'b1;
        S_axis.tdata  = stim[si].data;
        S_axis.tkeep  = stim[si].keep;
        S_axis.tlast  = stim[si].last;
        S_axis.tuser  = stim[si].user;
      end else begin
        S_axis.tvalid = 1'b0;
      end
      if (toggle) M_axis.tready = ~M_axis.tready;
      #1;
      if (tests[t].has_pad && si == stim.size() && S_axis.tready) pad_rdy++;
      if (M_axis.tvalid && M_axis.tready && exp.size() > 0) begin
        got.data = M_axis.tdata; got.keep = M_axis.tkeep;
        got.last = M_axis.tlast; got.user = M_axis.tuser;
        check_beat(tests[t].name, oi, got, exp.pop_front());
        oi++;
      end
      if (S_axis.tvalid && S_axis.tready) si++;
      cyc++;
    end

    if (cyc >= 400) begin
      n_vec++;
      n_fail++;
      $display("FAIL %s timeout: %0d inputs sent, %0d outputs still expected", tests[t].name, si, exp.size());
    end

    if (!abort_pad) begin
      if (tests[t].has_pad) check_val({tests[t].name, "_pad_tready"}, 64'(pad_rdy), 64'd0);
      S_axis.tvalid = 1'b0;
      M_axis.tready = 1'b1;
      repeat (3) begin
        @(negedge Clk);
        #1;
        if (M_axis.tvalid) busy++;
      end
      check_val({tests[t].name, "_no_extra"}, 64'(busy), 64'd0);
    end
  endtask

  initial begin
    Rst           = 1'b1;
    S_axis.tvalid = 1'b0;
    S_axis.tdata  = '0;
    S_axis.tkeep  = '0;
    S_axis.tlast  = 1'b0;
    S_axis.tuser  = 1'b0;
    M_axis.tready = 1'b1;

    // enc3: 3 bytes, P=13
    add_row(1, 64'hEEEE_EEEE_EEC3_B2A1, 8'h07, 1, 1, 64'h0D0D_0D0D_0DC3_B2A1, 8'hFF, 0);
    add_row(0, 64'h0, 8'h00, 0, 1, 64'h0D0D_0D0D_0D0D_0D0D, 8'hFF, 1);
    add_test("enc3", 1'b1, 2, 1'b1);
    // enc16: block-aligned, a full block of 0x10 follows
    add_row(1, 64'h0706_0504_0302_0100, 8'hFF, 0, 1, 64'h0706_0504_0302_0100, 8'hFF, 0);
    add_row(1, 64'h0F0E_0D0C_0B0A_0908, 8'hFF, 1, 1, 64'h0F0E_0D0C_0B0A_0908, 8'hFF, 0);
    add_row(0, 64'h0, 8'h00, 0, 1, 64'h1010_1010_1010_1010, 8'hFF, 0);
    add_row(0, 64'h0, 8'h00, 0, 1, 64'h1010_1010_1010_1010, 8'hFF, 1);
    add_test("enc16", 1'b1, 4, 1'b1);
    // enc9: P=7 fits inside the last beat
    add_row(1, 64'h8877_6655_4433_2211, 8'hFF, 0, 1, 64'h8877_6655_4433_2211, 8'hFF, 0);
    add_row(1, 64'hEEEE_EEEE_EEEE_EE42, 8'h01, 1, 1, 64'h0707_0707_0707_0742, 8'hFF, 1);
    add_test("enc9", 1'b1, 2, 1'b0);
    // dec32: passthrough
    add_row(1, 64'hA0A1_A2A3_A4A5_A6A7, 8'hFF, 0, 1, 64'hA0A1_A2A3_A4A5_A6A7, 8'hFF, 0);
    add_row(1, 64'hB0B1_B2B3_B4B5_B6B7, 8'hFF, 0, 1, 64'hB0B1_B2B3_B4B5_B6B7, 8'hFF, 0);
    add_row(1, 64'hC0C1_C2C3_C4C5_C6C7, 8'hFF, 0, 1, 64'hC0C1_C2C3_C4C5_C6C7, 8'hFF, 0);
    add_row(1, 64'hD0D1_D2D3_D4D5_D6D7, 8'hFF, 1, 1, 64'hD0D1_D2D3_D4D5_D6D7, 8'hFF, 1);
    add_test("dec32", 1'b0, 4, 1'b0);
    // enc24: full last beat mid-block, P=8 as one extra word
    add_row(1, 64'h1111_1111_1111_1111, 8'hFF, 0, 1, 64'h1111_1111_1111_1111, 8'hFF, 0);
    add_row(1, 64'h2222_2222_2222_2222, 8'hFF, 0, 1, 64'h2222_2222_2222_2222, 8'hFF, 0);
    add_row(1, 64'h3333_3333_3333_3333, 8'hFF, 1, 1, 64'h3333_3333_3333_3333, 8'hFF, 0);
    add_row(0, 64'h0, 8'h00, 0, 1, 64'h0808_0808_0808_0808, 8'hFF, 1);
    add_test("enc24", 1'b1, 4, 1'b1);
    // enc12: P=4 completes the block inside the last beat
    add_row(1, 64'h0102_0304_0506_0708, 8'hFF, 0, 1, 64'h0102_0304_0506_0708, 8'hFF, 0);
    add_row(1, 64'hEEEE_EEEE_CCBB_AA99, 8'h0F, 1, 1, 64'h0404_0404_CCBB_AA99, 8'hFF, 1);
    add_test("enc12", 1'b1, 2, 1'b0);

    repeat (2) @(negedge Clk);
    #1;
    check_val("rst_s_tready", 64'(S_axis.tready), 64'd0);
    check_val("rst_m_ctrl", 64'({M_axis.tvalid, M_axis.tlast, M_axis.tuser, M_axis.tkeep}), 64'd0);
    check_val("rst_m_tdata", M_axis.tdata, 64'd0);
`ifdef AES_PAD_ERR_EN
    check_val("rst_pad_error", 64'(Pad_error), 64'd0);
`endif
    @(negedge Clk);
    Rst = 1'b0;
    #1;
    check_val("idle_s_tready", 64'(S_axis.tready), 64'd1);

    foreach (tests[i]) run_msg(i, 1'b0, 1'b0);

    // enc16 again with M_axis.tready toggling every cycle
    run_msg(1, 1'b1, 1'b0);

    // Reset while the enc16 pad words are pending
    run_msg(1, 1'b0, 1'b1);
    @(negedge Clk);
    S_axis.tvalid = 1'b0;
    Rst           = 1'b1;
    #1;
    check_val("pad_s_tready", 64'(S_axis.tready), 64'd0);
    @(negedge Clk);
    #1;
    check_val("abort_m_ctrl", 64'({M_axis.tvalid, M_axis.tlast, M_axis.tuser, M_axis.tkeep}), 64'd0);
    check_val("abort_m_tdata", M_axis.tdata, 64'd0);
    Rst = 1'b0;
    run_msg(0, 1'b0, 1'b0);

`ifdef AES_PAD_ERR_EN
    check_val("final_pad_error", 64'(Pad_error), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
